// File: rtl/sum3_block_accum_if.sv
// ============================================================================
// sum3_block_accum_if : handshake bundle between the 3-operand adder, the
//                       block accumulator and the result sink. Rev 1.0
// ============================================================================
`default_nettype none

interface sum3_block_accum_if #(
  parameter int ACC_W = 8,
  parameter int CNT_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_sum;
  logic             clear;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic [CNT_W-1:0] out_count;
  logic             overflow;

  modport slave (
    input  in_valid, in_sum, clear, out_ready,
    output in_ready, out_valid, out_acc, out_count, overflow
  );

  modport master (
    output in_valid, in_sum, clear, out_ready,
    input  in_ready, out_valid, out_acc, out_count, overflow
  );
endinterface

`default_nettype wire

// File: rtl/sum3_block_accum.sv
// ============================================================================
// sum3_block_accum : sums BLOCK_LEN 4-bit adder results per block and holds
//                    the total until taken. Option: SUM3_ACCUM_SAT_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module sum3_block_accum #(
  parameter int ACC_W     = 8,
  parameter int BLOCK_LEN = 4
) (
  input  wire                 clk,
  input  wire                 rst_n,
  sum3_block_accum_if.slave   bus
);
  localparam int CNT_W = $clog2(BLOCK_LEN + 1);
  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(BLOCK_LEN - 1);

  localparam logic [0:0] S_ACCUM = 1'b0;
  localparam logic [0:0] S_HOLD  = 1'b1;

  logic [0:0]       r_state;
  logic [0:0]       w_next;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;
  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_accept;
  logic             w_xfer;
  logic [ACC_W:0]   w_sum;
  logic             w_carry;

  assign w_accept = bus.in_valid & w_in_ready;
  assign w_xfer   = w_out_valid & bus.out_ready;
  assign w_sum    = {1'b0, r_acc} + {{(ACC_W - 3){1'b0}}, bus.in_sum};
  assign w_carry  = w_sum[ACC_W];

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_ACCUM;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (bus.clear) begin
      w_next = S_ACCUM;
    end else begin
      case (r_state)
        S_ACCUM: if (w_accept && r_count == c_LAST) w_next = S_HOLD;
        S_HOLD:  if (w_xfer) w_next = S_ACCUM;
        default: w_next = S_ACCUM;
      endcase
    end
  end

  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_ACCUM: w_in_ready  = 1'b1;
      S_HOLD:  w_out_valid = 1'b1;
      default: w_in_ready  = 1'b1;
    endcase
  end

  // clear outranks both Transfer and accept; the sum offered with it is lost.
  always_ff @(posedge clk) begin
    if (!rst_n || bus.clear || w_xfer) begin
      r_acc      <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      r_count    <= r_count + 1'b1;
      r_overflow <= r_overflow | w_carry;
`ifdef SUM3_ACCUM_SAT_EN
      if (w_carry || r_overflow) r_acc <= '1;
      else                       r_acc <= w_sum[ACC_W-1:0];
`else
      r_acc <= w_sum[ACC_W-1:0];
`endif
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_acc   = r_acc;
  assign bus.out_count = r_count;
  assign bus.overflow  = r_overflow;
endmodule

`default_nettype wire

// File: tb/tb_sum3_block_accum.sv
// ============================================================================
// tb_sum3_block_accum : directed vectors plus hand sequences for the block
//                       accumulator (ACC_W=8/5, BLOCK_LEN=4/1). Rev 1.0
// ============================================================================
`default_nettype none

module tb_sum3_block_accum;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sum3_block_accum_if #(.ACC_W(8), .CNT_W(3)) bus8 ();
  sum3_block_accum_if #(.ACC_W(5), .CNT_W(3)) bus5 ();
  sum3_block_accum_if #(.ACC_W(8), .CNT_W(1)) bus1 ();

  sum3_block_accum #(.ACC_W(8), .BLOCK_LEN(4)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  sum3_block_accum #(.ACC_W(5), .BLOCK_LEN(4)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));
  sum3_block_accum #(.ACC_W(8), .BLOCK_LEN(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  typedef struct {
    bit v; int s; bit c; bit r;
    bit e_rdy; bit e_val; int e_acc; int e_cnt; bit e_of;
  } vec_t;

  vec_t tbl[$];
  int n_pass = 0;
  int n_total = 0;

`ifdef SUM3_ACCUM_SAT_EN
  localparam int EXP5_FINAL = 31;
  localparam int EXP5_MID   = 31;
`else
  localparam int EXP5_FINAL = 28;
  localparam int EXP5_MID   = 13;
`endif

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic step(input bit v, input int s, input bit c, input bit r);
    bus8.in_valid = v; bus8.in_sum = 4'(s); bus8.clear = c; bus8.out_ready = r;
    bus5.in_valid = v; bus5.in_sum = 4'(s); bus5.clear = c; bus5.out_ready = r;
    bus1.in_valid = v; bus1.in_sum = 4'(s); bus1.clear = c; bus1.out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input bit v, input int s, input bit c, input bit r,
                     input bit e_rdy, input bit e_val, input int e_acc,
                     input int e_cnt, input bit e_of);
    vec_t t;
    t.v = v; t.s = s; t.c = c; t.r = r;
    t.e_rdy = e_rdy; t.e_val = e_val; t.e_acc = e_acc; t.e_cnt = e_cnt; t.e_of = e_of;
    tbl.push_back(t);
  endtask

  task automatic chk8(input string tag, input bit rdy, input bit val,
                      input int acc, input int cnt, input bit of);
    chk({tag, ".in_ready"},  int'(bus8.in_ready),  int'(rdy));
    chk({tag, ".out_valid"}, int'(bus8.out_valid), int'(val));
    chk({tag, ".out_acc"},   int'(bus8.out_acc),   acc);
    chk({tag, ".out_count"}, int'(bus8.out_count), cnt);
    chk({tag, ".overflow"},  int'(bus8.overflow),  int'(of));
  endtask

  initial begin
    //   v  s  c  r   rdy val acc cnt of
    add(1, 3, 0, 0,   1, 0,  3, 1, 0);
    add(1, 5, 0, 0,   1, 0,  8, 2, 0);
    add(1, 7, 0, 0,   1, 0, 15, 3, 0);
    add(1, 9, 0, 0,   0, 1, 24, 4, 0);
    for (int i = 0; i < 6; i++) add(1, 1, 0, 0, 0, 1, 24, 4, 0);
    add(1, 1, 0, 1,   1, 0,  0, 0, 0);
    add(1, 2, 0, 0,   1, 0,  2, 1, 0);
    add(0, 0, 1, 0,   1, 0,  0, 0, 0);
    add(1, 4, 0, 0,   1, 0,  4, 1, 0);
    add(1, 6, 0, 0,   1, 0, 10, 2, 0);
    add(1, 2, 1, 0,   1, 0,  0, 0, 0);
    add(1, 1, 0, 0,   1, 0,  1, 1, 0);
    add(1, 1, 0, 0,   1, 0,  2, 2, 0);
    add(1, 1, 0, 0,   1, 0,  3, 3, 0);
    add(1, 1, 0, 0,   0, 1,  4, 4, 0);
    add(0, 0, 0, 1,   1, 0,  0, 0, 0);
    add(1, 2, 0, 0,   1, 0,  2, 1, 0);
    add(0, 2, 0, 0,   1, 0,  2, 1, 0);
    add(1, 2, 0, 0,   1, 0,  4, 2, 0);
    add(0, 2, 0, 0,   1, 0,  4, 2, 0);
    add(1, 2, 0, 0,   1, 0,  6, 3, 0);
    add(0, 2, 0, 0,   1, 0,  6, 3, 0);
    add(1, 2, 0, 0,   0, 1,  8, 4, 0);
    // clear in HOLD wins over a simultaneous Transfer and discards the total
    add(0, 0, 1, 1,   1, 0,  0, 0, 0);

    rst_n = 1'b0;
    step(0, 0, 0, 0);
    step(1, 7, 0, 1);
    chk8("reset", 1, 0, 0, 0, 0);
    rst_n = 1'b1;
    step(0, 0, 0, 0);
    chk8("idle", 1, 0, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].v, tbl[i].s, tbl[i].c, tbl[i].r);
      chk8($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_val,
           tbl[i].e_acc, tbl[i].e_cnt, tbl[i].e_of);
    end

    // Overflow on the narrow accumulator, and BLOCK_LEN=1 going straight to HOLD
    rst_n = 1'b0;
    step(0, 0, 0, 0);
    rst_n = 1'b1;
    step(1, 15, 0, 0);
    chk("blk1.out_valid", int'(bus1.out_valid), 1);
    chk("blk1.in_ready",  int'(bus1.in_ready),  0);
    chk("blk1.out_acc",   int'(bus1.out_acc),   15);
    chk("blk1.out_count", int'(bus1.out_count), 1);
    step(1, 15, 0, 0);
    chk("w5.ovf_clear_2", int'(bus5.overflow), 0);
    chk("w5.acc_2",       int'(bus5.out_acc),  30);
    step(1, 15, 0, 0);
    chk("w5.ovf_3",       int'(bus5.overflow), 1);
    chk("w5.acc_3",       int'(bus5.out_acc),  EXP5_MID);
    step(1, 15, 0, 0);
    chk("w5.acc_final",   int'(bus5.out_acc),   EXP5_FINAL);
    chk("w5.ovf_final",   int'(bus5.overflow),  1);
    chk("w5.out_valid",   int'(bus5.out_valid), 1);
    chk("w5.out_count",   int'(bus5.out_count), 4);
    chk8("w8.sixty", 0, 1, 60, 4, 0);
    step(0, 0, 0, 1);
    chk("w5.ovf_xfer",    int'(bus5.overflow), 0);
    chk("w5.acc_xfer",    int'(bus5.out_acc),  0);

    // Reset mid-block, then a fresh block totals from zero
    step(1, 1, 0, 0);
    step(1, 2, 0, 0);
    step(1, 3, 0, 0);
    chk8("pre_rst", 1, 0, 6, 3, 0);
    rst_n = 1'b0;
    step(1, 4, 0, 0);
    chk8("mid_rst", 1, 0, 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1, 5, 0, 0);
    chk8("post_rst", 0, 1, 20, 4, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

`default_nettype wire
